// File: rtl/path_count_pkg.sv
// Shared types for the path-counting traversal and the adjacency map.
// Contents:
//   node_t      - node identifier
//   count_t     - path counter
//   stack_ptr_t - LIFO fill level (one extra bit so a full stack can be represented)
//   dfs_state_t - traversal FSM states
package path_count_pkg;

   localparam int unsigned MaxNodes   = 1024;
   localparam int unsigned NodeWidth  = $clog2(MaxNodes);
   localparam int unsigned StackDepth = 512;
   localparam int unsigned CountWidth = 64;

   typedef logic [NodeWidth-1:0]        node_t;
   typedef logic [CountWidth-1:0]       count_t;
   typedef logic [$clog2(StackDepth):0] stack_ptr_t;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StCheck,
      StQuery,
      StReply,
      StDone
   } dfs_state_t;

endpackage

// File: rtl/lifo_stack.sv
// LIFO of pending nodes: distributed RAM plus a fill-level pointer.
// Ports:
//   clk, rst_n - clock, async active-low reset (clears the fill level only)
//   clear      - synchronous empty; a push in the same cycle lands in entry 0
//   push, pop  - push is ignored when full, pop is ignored when empty
//   data_in    - word to push
//   top        - combinational top-of-stack (undefined while empty)
//   empty/full - fill status
module lifo_stack #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [AddrWidth:0]   level_q, level_d;
   logic [AddrWidth-1:0] wr_addr, rd_addr;
   logic                 do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == (AddrWidth + 1)'(DEPTH));

   always_comb begin
      do_push = push && (clear || !full);
      do_pop  = pop && !clear && !empty;
      wr_addr = clear ? '0 : level_q[AddrWidth-1:0];
      // Wraps to DEPTH-1 when full, which is the correct top for a power-of-two depth.
      rd_addr = level_q[AddrWidth-1:0] - AddrWidth'(1);

      level_d = level_q;
      if (clear) begin
         level_d = do_push ? (AddrWidth + 1)'(1) : '0;
      end else if (do_push) begin
         level_d = level_q + (AddrWidth + 1)'(1);
      end else if (do_pop) begin
         level_d = level_q - (AddrWidth + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   // No reset on the storage so it maps onto LUT RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_addr] <= data_in;
      end
   end

   assign top = mem_q[rd_addr];

endmodule

// File: rtl/dfs_path_counter.sv
// Counts distinct start->target paths in a DAG by iterative depth-first traversal,
// querying an external adjacency map for the successors of each expanded node.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   start, start_node, target_node - launch a traversal (accepted in IDLE/DONE only)
//   query_valid/ready, query_data  - node expansion request to the map
//   reply_valid/ready, reply_data,
//   reply_last, reply_no_edges_found - successor beats from the map
//   busy                           - traversal in progress
//   done, path_count               - result, held until the next start
//   overflow                       - sticky: stack entry dropped or count saturated
module dfs_path_counter
   import path_count_pkg::*;
#(
   parameter int unsigned MAX_NODES   = MaxNodes,
   parameter int unsigned NODE_WIDTH  = $clog2(MAX_NODES),
   parameter int unsigned STACK_DEPTH = StackDepth,
   parameter int unsigned COUNT_WIDTH = CountWidth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NODE_WIDTH-1:0]  start_node,
   input  logic [NODE_WIDTH-1:0]  target_node,
   input  logic                   query_ready,
   output logic                   query_valid,
   output logic [NODE_WIDTH-1:0]  query_data,
   input  logic                   reply_valid,
   output logic                   reply_ready,
   input  logic [NODE_WIDTH-1:0]  reply_data,
   input  logic                   reply_last,
   input  logic                   reply_no_edges_found,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] path_count,
   output logic                   overflow
);

   if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("STACK_DEPTH must be a power of two of at least 2");
   end
   if (NODE_WIDTH < $clog2(MAX_NODES)) begin : g_bad_width
      $error("NODE_WIDTH too narrow for MAX_NODES");
   end

   dfs_state_t             state_q, state_d;
   logic [NODE_WIDTH-1:0]  cur_node_q, cur_node_d;
   logic [NODE_WIDTH-1:0]  target_q, target_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   overflow_q, overflow_d;

   logic                   stk_clear, stk_push, stk_pop, stk_empty, stk_full;
   logic [NODE_WIDTH-1:0]  stk_din, stk_top;

   logic                   start_ok, beat_push, is_target;

   assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
   // reply_ready is high throughout REPLY, so any valid beat there is accepted.
   assign beat_push = (state_q == StReply) && reply_valid && !reply_no_edges_found;
   assign is_target = (cur_node_q == target_q);

   lifo_stack #(
      .DEPTH(STACK_DEPTH),
      .WIDTH(NODE_WIDTH)
   ) u_stack (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (stk_clear),
      .push   (stk_push),
      .pop    (stk_pop),
      .data_in(stk_din),
      .top    (stk_top),
      .empty  (stk_empty),
      .full   (stk_full)
   );

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StPop;
         StPop:          state_d = stk_empty ? StDone : StCheck;
         StCheck:        state_d = is_target ? StPop : StQuery;
         StQuery:        if (query_ready) state_d = StReply;
         StReply:        if (reply_valid && reply_last) state_d = StPop;
         default:        state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      query_valid = (state_q == StQuery);
      reply_ready = (state_q == StReply);
      busy        = (state_q != StIdle) && (state_q != StDone);
      done        = (state_q == StDone);
      // cur_node only changes in POP, so the request stays stable while stalled.
      query_data  = cur_node_q;
      path_count  = count_q;
      overflow    = overflow_q;
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      stk_clear  = start_ok;
      stk_push   = start_ok || beat_push;
      stk_din    = start_ok ? start_node : reply_data;
      stk_pop    = (state_q == StPop) && !stk_empty;

      cur_node_d = stk_pop ? stk_top : cur_node_q;
      target_d   = start_ok ? target_node : target_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (start_ok) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if ((state_q == StCheck) && is_target) begin
            if (&count_q) begin
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + COUNT_WIDTH'(1);
            end
         end
         // Dropped successor: traversal carries on so the block always terminates.
         if (beat_push && stk_full) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_node_q <= '0;
         target_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         cur_node_q <= cur_node_d;
         target_q   <= target_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_dfs_path_counter.sv
// Bench for dfs_path_counter: a behavioural map answers queries from a graph table,
// a reference DFS predicts queries and results, and a monitor scores each result.
module tb_dfs_path_counter;

   localparam int NW      = 10;
   localparam int DEPTH   = 4;
   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int NN      = 16;
   localparam int MAXDEG  = 8;

   typedef struct {
      int cnt;
      bit ovf;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [NW-1:0] start_node = '0;
   logic [NW-1:0] target_node = '0;
   logic          query_ready;
   logic          query_valid;
   logic [NW-1:0] query_data;
   logic          reply_valid;
   logic          reply_ready;
   logic [NW-1:0] reply_data;
   logic          reply_last;
   logic          reply_no_edges_found;
   logic          busy;
   logic          done;
   logic [CW-1:0] path_count;
   logic          overflow;

   int            checks = 0;
   int            failures = 0;
   string         cur_case = "init";

   int            adj_n [NN];
   logic [NW-1:0] adj_s [NN][MAXDEG];
   int            exp_query_q [$];
   res_t          exp_res_q [$];

   int            stall_mode = 0;   // 0: none, 1: seven cycles, 2: random 0..3
   bit            gap_mode = 0;
   bit            reset_in_reply = 0;

   dfs_path_counter #(
      .MAX_NODES  (1024),
      .NODE_WIDTH (NW),
      .STACK_DEPTH(DEPTH),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .start_node          (start_node),
      .target_node         (target_node),
      .query_ready         (query_ready),
      .query_valid         (query_valid),
      .query_data          (query_data),
      .reply_valid         (reply_valid),
      .reply_ready         (reply_ready),
      .reply_data          (reply_data),
      .reply_last          (reply_last),
      .reply_no_edges_found(reply_no_edges_found),
      .busy                (busy),
      .done                (done),
      .path_count          (path_count),
      .overflow            (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL [%s] %s: actual=%0d required=%0d", cur_case, name, act, exp);
      end
   endtask

   task automatic clear_graph();
      for (int i = 0; i < NN; i++) adj_n[i] = 0;
   endtask

   task automatic add_edge(input int u, input int v);
      adj_s[u][adj_n[u]] = NW'(v);
      adj_n[u]++;
   endtask

   // Reference DFS with a bounded LIFO and a saturating counter.
   task automatic model_run(input int root, input int target, output int cnt, output bit ovf);
      int stk[$];
      int node;
      cnt = 0;
      ovf = 0;
      stk.push_back(root);
      while (stk.size() > 0) begin
         node = stk.pop_back();
         if (node == target) begin
            if (cnt == CNT_MAX) ovf = 1;
            else cnt++;
         end else begin
            exp_query_q.push_back(node);
            for (int i = 0; i < adj_n[node]; i++) begin
               if (stk.size() < DEPTH) stk.push_back(int'(adj_s[node][i]));
               else ovf = 1;
            end
         end
      end
   endtask

   task automatic check_reset_values();
      check("rst_query_valid", query_valid, 0);
      check("rst_reply_ready", reply_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_path_count", path_count, 0);
      check("rst_query_data", query_data, 0);
   endtask

   task automatic send_beat(input logic [NW-1:0] d, input bit last, input bit noedge);
      if (gap_mode) begin
         repeat ($urandom_range(0, 2)) begin
            reply_valid = 1'b0;
            @(negedge clk);
         end
      end
      check("reply_ready", reply_ready, 1);
      reply_valid          = 1'b1;
      reply_data           = d;
      reply_last           = last;
      reply_no_edges_found = noedge;
      @(negedge clk);
   endtask

   // Behavioural adjacency map.
   initial begin : responder
      int node;
      int stall;
      int deg;
      query_ready          = 1'b0;
      reply_valid          = 1'b0;
      reply_data           = '0;
      reply_last           = 1'b0;
      reply_no_edges_found = 1'b0;
      forever begin
         @(negedge clk);
         if (query_valid && rst_n) begin
            node  = int'(query_data);
            stall = (stall_mode == 1) ? 7 : ((stall_mode == 2) ? $urandom_range(0, 3) : 0);
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               check("query_hold_valid", query_valid, 1);
               check("query_hold_data", query_data, node);
            end
            query_ready = 1'b1;
            @(negedge clk);
            query_ready = 1'b0;
            if (exp_query_q.size() == 0) check("query_unexpected", node, -1);
            else check("query_node", node, exp_query_q.pop_front());
            if (!reset_in_reply) begin
               deg = (node < NN) ? adj_n[node] : 0;
               if (deg == 0) begin
                  if ($urandom_range(0, 1) == 1) send_beat(NW'($urandom_range(0, 15)), 1'b0, 1'b1);
                  send_beat(NW'($urandom_range(0, 15)), 1'b1, 1'b1);
               end else begin
                  for (int i = 0; i < deg; i++) send_beat(adj_s[node][i], i == deg - 1, 1'b0);
               end
               reply_valid          = 1'b0;
               reply_last           = 1'b0;
               reply_no_edges_found = 1'b0;
            end
         end
      end
   end

   // Scores each completed traversal against the queued expectation.
   initial begin : monitor
      bit   prev;
      res_t r;
      prev = 0;
      forever begin
         @(negedge clk);
         if (done && !prev) begin
            if (exp_res_q.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               r = exp_res_q.pop_front();
               check("path_count", path_count, r.cnt);
               check("overflow", overflow, r.ovf);
            end
         end
         prev = done;
      end
   end

   task automatic run_case(input int root, input int target, input int exp_lat, input bit chk_qv,
                           input bit poke);
      int   cnt;
      bit   ovf;
      int   n;
      res_t r;
      model_run(root, target, cnt, ovf);
      r.cnt = cnt;
      r.ovf = ovf;
      exp_res_q.push_back(r);
      @(negedge clk);
      start_node  = NW'(root);
      target_node = NW'(target);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_after_start", busy, 1);
      while (!done && n < 3000) begin
         if (chk_qv && n <= 3) check("query_valid_timing", query_valid, n == 3);
         if (poke && n == 5) begin
            start_node  = NW'(1);
            target_node = NW'(1);
            start       = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!done) begin
         check("done_timeout", n, -1);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         exp_res_q.delete();
         exp_query_q.delete();
      end else begin
         if (exp_lat > 0) check("done_latency", n, exp_lat);
         check("queries_consumed", exp_query_q.size(), 0);
         check("busy_at_done", busy, 0);
      end
   endtask

   task automatic diamond();
      clear_graph();
      add_edge(0, 1);
      add_edge(0, 2);
      add_edge(1, 3);
      add_edge(2, 3);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL [%s] watchdog: actual=timeout required=finish", cur_case);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cnt;
      bit ovf;
      int n;

      cur_case = "reset";
      repeat (3) @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      @(negedge clk);

      cur_case = "single_node";
      clear_graph();
      run_case(5, 5, 4, 0, 0);

      cur_case = "diamond";
      diamond();
      run_case(0, 3, 0, 1, 0);

      cur_case = "dead_end";
      clear_graph();
      add_edge(0, 1);
      add_edge(0, 4);
      add_edge(1, 3);
      run_case(0, 3, 0, 1, 0);

      cur_case = "backpressure";
      diamond();
      stall_mode = 1;
      gap_mode   = 1;
      run_case(0, 3, 0, 0, 1);
      stall_mode = 0;
      gap_mode   = 0;

      cur_case = "stack_overflow";
      clear_graph();
      for (int v = 1; v <= 6; v++) add_edge(0, v);
      run_case(0, 7, 0, 0, 0);

      cur_case = "count_saturation";
      clear_graph();
      for (int u = 1; u <= 3; u++) begin
         add_edge(0, u);
         add_edge(u, 9);
         add_edge(u, 9);
      end
      run_case(0, 9, 0, 0, 0);

      cur_case = "reset_mid_reply";
      diamond();
      model_run(0, 3, cnt, ovf);
      reset_in_reply = 1;
      @(negedge clk);
      start_node  = NW'(0);
      target_node = NW'(3);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!reply_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_reply", reply_ready, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      reset_in_reply = 0;
      exp_query_q.delete();
      run_case(0, 3, 0, 1, 0);

      cur_case = "random";
      stall_mode = 2;
      gap_mode   = 1;
      for (int g = 0; g < 20; g++) begin
         clear_graph();
         for (int u = 0; u < 7; u++) begin
            repeat ($urandom_range(0, 3)) add_edge(u, $urandom_range(u + 1, 7));
         end
         run_case(0, $urandom_range(1, 7), 0, 0, 0);
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
